// File: rtl/flash_spi_sequencer.sv
// flash_spi_sequencer: single-I/O SPI transaction engine for the external QSPI flash.
// It sends an opcode, an optional 24-bit address, and then write or read bytes.
// It can then poll the status register (0x05) in a second frame until the busy bit clears.
module flash_spi_sequencer #(
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned CS_HIGH  = 4,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic        addr_en,
  input  logic [8:0]  wlen,
  input  logic [8:0]  rlen,
  input  logic        poll_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        fm_sck,
  output logic        fm_ce_n,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten,
  input  logic [3:0]  fm_din
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV);
  localparam logic [15:0] GAP_LAST = (CS_HIGH > 1) ? 16'(CS_HIGH - 1) : 16'd0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WSTALL,
    ST_RDATA,
    ST_TAIL,
    ST_GAP,
    ST_PCMD,
    ST_PREAD,
    ST_DONE
  } state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] poll_cnt;
  logic [2:0]  bit_cnt;
  logic [8:0]  byte_cnt;
  logic [6:0]  tx_sr;
  logic [6:0]  rx_sr;
  logic        mosi;
  logic [23:0] addr_q;
  logic        addr_en_q;
  logic        poll_en_q;
  logic [8:0]  wlen_q;
  logic [8:0]  rlen_q;
  logic        poll_stop;

  logic        tick;
  logic        miso;
  logic [7:0]  rx_byte;
  logic [7:0]  addr_next;
  logic [16:0] poll_next;
  logic [8:0]  wlen_eff;
  logic [8:0]  rlen_eff;
  logic        hdr_done;
  logic        need_wr;
  logic        unused_din;

  assign tick       = (div_cnt == DIV_LAST);
  assign miso       = fm_din[1];
  assign unused_din = ^{fm_din[3:2], fm_din[0]};
  assign rx_byte    = {rx_sr, miso};
  assign addr_next  = (byte_cnt == 9'd0) ? addr_q[15:8] : addr_q[7:0];
  assign poll_next  = {1'b0, poll_cnt} + 17'd1;
  assign wlen_eff   = (wlen > 9'd256) ? 9'd256 : wlen;
  assign rlen_eff   = (rlen > 9'd256) ? 9'd256 : rlen;

  // Header is complete at this byte boundary: opcode without address, or last address byte.
  assign hdr_done = ((state == ST_CMD) && !addr_en_q) ||
                    ((state == ST_ADDR) && (byte_cnt == 9'd2));
  // Another write byte must be fetched at this byte boundary.
  assign need_wr  = (hdr_done && (wlen_q != 9'd0)) ||
                    ((state == ST_WDATA) && (byte_cnt != wlen_q));

  assign fm_dout   = {3'b000, mosi};
  assign fm_douten = {3'b000, ~fm_ce_n};

  // Transaction sequencer: frame phases, SCK generation, byte shifting and handshakes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      mosi      <= 1'b0;
      addr_q    <= '0;
      addr_en_q <= 1'b0;
      poll_en_q <= 1'b0;
      wlen_q    <= '0;
      rlen_q    <= '0;
      poll_stop <= 1'b0;
      fm_sck    <= 1'b0;
      fm_ce_n   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      timeout   <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (tick) div_cnt <= '0;
      else      div_cnt <= div_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= addr;
            addr_en_q <= addr_en;
            poll_en_q <= poll_en;
            wlen_q    <= wlen_eff;
            rlen_q    <= rlen_eff;
            poll_stop <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            fm_ce_n   <= 1'b0;
            tx_sr     <= cmd[6:0];
            mosi      <= cmd[7];
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            div_cnt   <= '0;
            state     <= ST_CMD;
          end
        end

        ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_PCMD, ST_PREAD: begin
          if (tick && !fm_sck) begin
            fm_sck <= 1'b1;
            rx_sr  <= rx_byte[6:0];
            if (bit_cnt == 3'd7) begin
              if (state == ST_RDATA) begin
                rd_data  <= rx_byte;
                rd_valid <= 1'b1;
                byte_cnt <= byte_cnt + 9'd1;
              end
              if (state == ST_PREAD) begin
                rd_data  <= rx_byte;
                rd_valid <= 1'b1;
                poll_cnt <= poll_next[15:0];
                if (!rx_byte[0]) begin
                  poll_stop <= 1'b1;
                end else if (poll_next == {1'b0, POLL_MAX}) begin
                  poll_stop <= 1'b1;
                  timeout   <= 1'b1;
                end
              end
            end
          end else if (tick) begin
            fm_sck  <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              mosi  <= tx_sr[6];
              tx_sr <= {tx_sr[5:0], 1'b0};
            end else if (need_wr) begin
              if (wr_valid) begin
                tx_sr    <= wr_data[6:0];
                mosi     <= wr_data[7];
                wr_ready <= 1'b1;
                byte_cnt <= (state == ST_WDATA) ? byte_cnt + 9'd1 : 9'd1;
                state    <= ST_WDATA;
              end else begin
                mosi     <= 1'b0;
                byte_cnt <= (state == ST_WDATA) ? byte_cnt : 9'd0;
                state    <= ST_WSTALL;
              end
            end else if (hdr_done) begin
              tx_sr    <= '0;
              mosi     <= 1'b0;
              byte_cnt <= '0;
              state    <= (rlen_q != 9'd0) ? ST_RDATA : ST_TAIL;
            end else begin
              tx_sr <= '0;
              mosi  <= 1'b0;
              case (state)
                ST_CMD: begin
                  tx_sr    <= addr_q[22:16];
                  mosi     <= addr_q[23];
                  byte_cnt <= '0;
                  state    <= ST_ADDR;
                end
                ST_ADDR: begin
                  tx_sr    <= addr_next[6:0];
                  mosi     <= addr_next[7];
                  byte_cnt <= byte_cnt + 9'd1;
                end
                ST_PCMD:  state <= ST_PREAD;
                ST_RDATA: if (byte_cnt == rlen_q) state <= ST_TAIL;
                ST_PREAD: if (poll_stop) state <= ST_TAIL;
                default:  state <= ST_TAIL;
              endcase
            end
          end
        end

        ST_WSTALL: begin
          if (wr_valid) begin
            tx_sr    <= wr_data[6:0];
            mosi     <= wr_data[7];
            wr_ready <= 1'b1;
            byte_cnt <= byte_cnt + 9'd1;
            div_cnt  <= '0;
            state    <= ST_WDATA;
          end
        end

        ST_TAIL: begin
          if (tick) begin
            fm_ce_n <= 1'b1;
            mosi    <= 1'b0;
            gap_cnt <= '0;
            if (poll_stop) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (poll_en_q) begin
              fm_ce_n   <= 1'b0;
              tx_sr     <= 7'h05;
              mosi      <= 1'b0;
              bit_cnt   <= '0;
              div_cnt   <= '0;
              poll_cnt  <= '0;
              poll_stop <= 1'b0;
              state     <= ST_PCMD;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/flash_spi_sequencer.md
Name: flash_spi_sequencer

Overview:
- Hardware SPI command sequencer for the external QSPI flash. Replaces per-bit software bit-banging with a single transaction engine.
- Issues one serial (single-I/O) command frame: opcode, optional 24-bit address, N write bytes or N read bytes. Can then poll the status register until the flash is no longer busy.
- Drives the same fm_* flash pin group as the bit-bang writer and sits behind an AHB register front-end. Pin muxing against the flash reader stays outside this block.

Parameters:
- CLK_DIV, 1, SCK half-period = CLK_DIV+1 HCLK cycles (SCK = HCLK/(2*(CLK_DIV+1))).
- CS_HIGH, 4, minimum HCLK cycles ce_n stays high between the command frame and the poll frame.
- POLL_MAX, 16'hFFFF, maximum status bytes read while polling before timeout.

Ports:
- HCLK in 1: clock.
- HRESETn in 1: asynchronous active-low reset.
- start in 1: one-cycle pulse; accepted only when busy=0.
- cmd in 8: opcode.
- addr in 24: flash address, sent MSB first.
- addr_en in 1: send addr after opcode.
- wlen in 9: write bytes to send, 0..256.
- rlen in 9: read bytes to receive, 0..256. Only used when wlen=0.
- poll_en in 1: poll status (opcode 0x05) after frame until bit0=0.
- wr_data in 8: write byte.
- wr_valid in 1: write byte valid.
- wr_ready out 1: one-cycle pulse when wr_data is consumed.
- rd_data out 8: received byte.
- rd_valid out 1: one-cycle pulse per received byte; no backpressure.
- busy out 1: transaction in progress.
- done out 1: one-cycle pulse at end of transaction.
- timeout out 1: sticky poll timeout; cleared by the next accepted start.
- fm_sck out 1: flash clock.
- fm_ce_n out 1: flash chip select.
- fm_dout out 4: bit0 = MOSI, bits 3:1 = 0.
- fm_douten out 4: 4'b0001 while ce_n=0, otherwise 4'b0000.
- fm_din in 4: bit1 = MISO.

Behaviour:
- Reset values: fm_sck=0, fm_ce_n=1, fm_dout=0, fm_douten=0, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, timeout=0.
- Reset asserted mid-transaction aborts immediately to IDLE with pins at reset values; no done pulse.
- SPI mode 0, MSB first:
  - MOSI is updated while SCK is low; MISO is sampled on the HCLK cycle where SCK rises.
  - ce_n falls one half-period before the first SCK rise.
  - ce_n rises one half-period after the last SCK fall.
- Bit/half-period counter: a CLK_DIV counter produces a tick every CLK_DIV+1 cycles; each tick toggles SCK.
- States:
  - IDLE -> CMD on start (inputs latched; start while busy is ignored).
  - CMD (8 bits) -> ADDR if addr_en; else WDATA if wlen!=0; else RDATA if rlen!=0; else END.
  - ADDR (24 bits) -> WDATA / RDATA / END by the same rule.
  - WDATA:
    - A byte is fetched at each byte boundary when wr_valid=1; wr_ready pulses that cycle.
    - If wr_valid=0 at a boundary, SCK holds low with ce_n low (stall) until wr_valid.
    - After wlen bytes -> END.
  - RDATA: after each 8th rising edge, rd_data is updated and rd_valid pulses. After rlen bytes -> END.
  - END: ce_n high; wait CS_HIGH cycles -> POLL if poll_en, else DONE.
  - POLL:
    - Send 0x05, then read status bytes continuously in one frame.
    - Each byte with bit0=0 ends the frame -> DONE.
    - Each status byte is also output on rd_data/rd_valid.
    - After POLL_MAX status bytes with bit0=1: set timeout, end the frame -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy=1 from the cycle after start through the DONE cycle.
- wlen and rlen are 9-bit; values >256 are treated as 256.
- wlen!=0 takes priority over rlen; rlen is ignored in that case.

Test Plan:
- CLK_DIV=1, start cmd=0x06, addr_en=0, wlen=rlen=0, poll_en=0 -> 8 SCK cycles; MOSI = 0,0,0,0,0,1,1,0; ce_n low for 34 HCLK; done pulse; busy drops.
- cmd=0x9F, rlen=3, fm_din[1] driving 0xEF,0x40,0x18 -> three rd_valid pulses with rd_data 0xEF, 0x40, 0x18 in order; 32 SCK rises total.
- cmd=0x02, addr=0x012345, wlen=4; wr_valid withheld for 20 cycles before byte 2 -> SCK frozen low, ce_n low during the stall; MOSI stream 02 01 23 45 then data bytes; exactly 4 wr_ready pulses.
- cmd=0x20 sector erase, addr_en=1, poll_en=1; status model returns 0x03 ×5 then 0x00 -> ce_n high ≥CS_HIGH cycles between frames; 6 status rd_valid pulses; done; timeout=0.
- POLL_MAX=3, status stuck at 0x01 -> exactly 3 status bytes; timeout=1; done pulse; next start clears timeout.
- HRESETn asserted during ADDR -> fm_ce_n=1, fm_sck=0, fm_douten=0, busy=0 asynchronously; no done pulse; new start after release runs normally.
